// File: rtl/map_infl_pkg.sv
// Shared types and helpers for the map-inflation window scheduler:
// scheduler state encoding, border width and the lane slicing macro.
`ifndef MAP_INFL_LANE_SLICE
`define MAP_INFL_LANE_SLICE(lane, dw) [(lane)*(dw) +: (dw)]
`endif

package map_infl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEAD  = 3'd1,
    RUN   = 3'd2,
    TRAIL = 3'd3,
    DRAIN = 3'd4
  } sched_state_t;

  // Border columns on each side of a row for an odd window of k rows.
  function automatic int pad_of(input int k);
    return k / 2;
  endfunction

endpackage

// File: rtl/axis_window_sched_out.sv
// Single-stage AXI-Stream output register carrying {tuser, tlast, tdata};
// holds its contents while the sink stalls.
module axis_out_reg
  import map_infl_pkg::*;
#(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         in_user,
  input  logic         in_last,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         out_user,
  output logic         out_last,
  output logic         load_en
);

  assign load_en = !out_valid || out_ready;

  // Output stage: reload whenever the held beat is gone or being taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_user  <= 1'b0;
      out_last  <= 1'b0;
    end else if (load_en) begin
      out_valid <= in_valid;
      out_user  <= in_valid & in_user;
      out_last  <= in_valid & in_last;
      if (in_valid) begin
        out_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/axis_window_sched.sv
// Row/column scheduler: joins the K lane streams, wraps every map row in
// PAD border columns and frames the output with SOF (tuser) / EOL (tlast).
module axis_window_sched
  import map_infl_pkg::*;
#(
  parameter int KERNEL_SIZE = 3,
  parameter int DATA_WIDTH  = 8,
  parameter int DIM_WIDTH   = 16,
  parameter int PAD_VALUE   = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [DIM_WIDTH-1:0]              cfg_width,
  input  logic [DIM_WIDTH-1:0]              cfg_height,
  output logic                              busy,
  output logic                              done,
  output logic                              err_cfg,
  input  logic [KERNEL_SIZE*DATA_WIDTH-1:0] s_tdata,
  input  logic [KERNEL_SIZE-1:0]            s_tvalid,
  output logic [KERNEL_SIZE-1:0]            s_tready,
  output logic [KERNEL_SIZE*DATA_WIDTH-1:0] m_tdata,
  output logic                              m_tvalid,
  input  logic                              m_tready,
  output logic                              m_tuser,
  output logic                              m_tlast
);

  localparam int PAD    = pad_of(KERNEL_SIZE);
  localparam int DW_ALL = KERNEL_SIZE * DATA_WIDTH;
  localparam logic [DIM_WIDTH-1:0]  ONE      = DIM_WIDTH'(1);
  localparam logic [DIM_WIDTH-1:0]  PAD_LAST = DIM_WIDTH'(PAD - 1);
  localparam logic [DATA_WIDTH-1:0] PAD_CELL = DATA_WIDTH'(PAD_VALUE);

  sched_state_t         state_r, state_s;
  logic [DIM_WIDTH-1:0] col_r, col_s;
  logic [DIM_WIDTH-1:0] row_r, row_s;
  logic [DIM_WIDTH-1:0] width_r, height_r;
  logic                 busy_r, done_r, err_r;
  logic                 done_s;
  logic                 start_ok_s, start_bad_s;
  logic                 load_en_s, pop_s;
  logic                 gen_valid_s, gen_user_s, gen_last_s;
  logic [DW_ALL-1:0]    gen_data_s;

  assign start_ok_s  = (state_r == IDLE) && start &&
                       (cfg_width != '0) && (cfg_height != '0);
  assign start_bad_s = (state_r == IDLE) && start &&
                       ((cfg_width == '0) || (cfg_height == '0));

  // Join: all lanes pop together, only with a full set and room downstream.
  assign pop_s    = (state_r == RUN) && (&s_tvalid) && load_en_s;
  assign s_tready = {KERNEL_SIZE{pop_s}};

  assign busy    = busy_r;
  assign done    = done_r;
  assign err_cfg = err_r;

  // State register, counters, latched frame geometry and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      col_r    <= '0;
      row_r    <= '0;
      width_r  <= '0;
      height_r <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      col_r   <= col_s;
      row_r   <= row_s;
      busy_r  <= (state_s != IDLE);
      done_r  <= done_s;
      err_r   <= start_bad_s;
      if (start_ok_s) begin
        width_r  <= cfg_width;
        height_r <= cfg_height;
      end
    end
  end

  // Next-state and counter logic; counters only move on a generated beat.
  always_comb begin
    state_s = state_r;
    col_s   = col_r;
    row_s   = row_r;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_ok_s) begin
          state_s = LEAD;
          col_s   = '0;
          row_s   = '0;
        end else begin
          state_s = IDLE;
        end
      end
      LEAD: begin
        if (gen_valid_s && (col_r == PAD_LAST)) begin
          state_s = RUN;
          col_s   = '0;
        end else if (gen_valid_s) begin
          col_s = col_r + ONE;
        end else begin
          col_s = col_r;
        end
      end
      RUN: begin
        if (gen_valid_s && (col_r == width_r - ONE)) begin
          state_s = TRAIL;
          col_s   = '0;
        end else if (gen_valid_s) begin
          col_s = col_r + ONE;
        end else begin
          col_s = col_r;
        end
      end
      TRAIL: begin
        if (gen_valid_s && (col_r == PAD_LAST)) begin
          col_s = '0;
          if (row_r == height_r - ONE) begin
            state_s = DRAIN;
          end else begin
            state_s = LEAD;
            row_s   = row_r + ONE;
          end
        end else if (gen_valid_s) begin
          col_s = col_r + ONE;
        end else begin
          col_s = col_r;
        end
      end
      DRAIN: begin
        // Nothing new is generated here, so load_en means the last beat leaves.
        if (load_en_s) begin
          state_s = IDLE;
          done_s  = 1'b1;
        end else begin
          state_s = DRAIN;
        end
      end
      default: begin
        state_s = IDLE;
        col_s   = '0;
        row_s   = '0;
      end
    endcase
  end

  // Beat generation: border columns carry PAD_CELL, RUN carries joined lanes.
  always_comb begin
    gen_valid_s = 1'b0;
    gen_user_s  = 1'b0;
    gen_last_s  = 1'b0;
    case (state_r)
      LEAD: begin
        gen_valid_s = load_en_s;
        gen_user_s  = (row_r == '0) && (col_r == '0);
      end
      RUN: begin
        gen_valid_s = pop_s;
      end
      TRAIL: begin
        gen_valid_s = load_en_s;
        gen_last_s  = (col_r == PAD_LAST);
      end
      default: begin
        gen_valid_s = 1'b0;
      end
    endcase
    gen_data_s = '0;
    for (int i = 0; i < KERNEL_SIZE; i++) begin
      if (state_r == RUN) begin
        gen_data_s `MAP_INFL_LANE_SLICE(i, DATA_WIDTH) = s_tdata `MAP_INFL_LANE_SLICE(i, DATA_WIDTH);
      end else begin
        gen_data_s `MAP_INFL_LANE_SLICE(i, DATA_WIDTH) = PAD_CELL;
      end
    end
  end

  axis_out_reg #(
    .W(DW_ALL)
  ) u_out (
    .clk      (clk),
    .rst      (rst),
    .in_valid (gen_valid_s),
    .in_data  (gen_data_s),
    .in_user  (gen_user_s),
    .in_last  (gen_last_s),
    .out_ready(m_tready),
    .out_valid(m_tvalid),
    .out_data (m_tdata),
    .out_user (m_tuser),
    .out_last (m_tlast),
    .load_en  (load_en_s)
  );

endmodule

// File: tb/tb_axis_window_sched.sv
// Randomized bench for axis_window_sched with a beat-list reference model
// built from the frame geometry and the lane data order.
module tb_axis_window_sched;

  localparam int K    = 3;
  localparam int DW   = 8;
  localparam int DIMW = 16;
  localparam int PAD  = 1;

  typedef struct packed {
    logic [K*DW-1:0] data;
    logic            user;
    logic            last;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [DIMW-1:0] cfg_width, cfg_height;
  logic            busy, done, err_cfg;
  logic [K*DW-1:0] s_tdata;
  logic [K-1:0]    s_tvalid, s_tready;
  logic [K*DW-1:0] m_tdata;
  logic            m_tvalid, m_tready, m_tuser, m_tlast;

  always #5 clk = ~clk;

  axis_window_sched #(
    .KERNEL_SIZE(K), .DATA_WIDTH(DW), .DIM_WIDTH(DIMW), .PAD_VALUE(0)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .busy(busy), .done(done), .err_cfg(err_cfg),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tuser(m_tuser), .m_tlast(m_tlast)
  );

  beat_t exp_q[$];
  int    n_cmp = 0, n_bad = 0;
  int    idx = 0, seed = 0, cyc = 0;
  bit    model_busy = 0, exp_done_next = 0, exp_err_next = 0;
  int    valid_pct = 100, ready_mode = 0, lane1_block = 0;
  bit    prev_stall = 0;
  beat_t prev_beat;
  int    acc_beats = 0, first_acc = 0, last_acc = 0, done_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] lane_val(input int i, input int j);
    return DW'(j * 37 + i * 101 + seed * 13 + 5);
  endfunction

  function automatic logic [K*DW-1:0] pack_col(input int j);
    logic [K*DW-1:0] v;
    for (int i = 0; i < K; i++) v[i*DW +: DW] = lane_val(i, j);
    return v;
  endfunction

  // Expected beat list: per row PAD borders, width data columns, PAD borders.
  task automatic build_model(input int w, input int h);
    int j = 0;
    exp_q.delete();
    for (int r = 0; r < h; r++) begin
      for (int p = 0; p < PAD; p++) exp_q.push_back('{data: '0, user: (r == 0 && p == 0), last: 1'b0});
      for (int c = 0; c < w; c++) begin
        exp_q.push_back('{data: pack_col(j), user: 1'b0, last: 1'b0});
        j++;
      end
      for (int p = 0; p < PAD; p++) exp_q.push_back('{data: '0, user: 1'b0, last: (p == PAD - 1)});
    end
  endtask

  task automatic step(input bit do_start, input int w, input int h);
    bit    blocked = 0;
    bit    exp_done;
    beat_t got, want;
    @(negedge clk);
    cyc++;
    exp_done = exp_done_next;
    exp_done_next = 0;
    check("done", done, exp_done);
    if (exp_done) begin
      model_busy = 0;
      done_cyc = cyc;
    end
    check("busy", busy, model_busy);
    check("err_cfg", err_cfg, exp_err_next);
    exp_err_next = 0;

    start = 1'b0;
    if (do_start) begin
      start = 1'b1;
      cfg_width = DIMW'(w);
      cfg_height = DIMW'(h);
      if (!model_busy) begin
        if (w == 0 || h == 0) exp_err_next = 1;
        else begin
          model_busy = 1;
          seed++;
          idx = 0;
          acc_beats = 0;
          build_model(w, h);
        end
      end
    end
    for (int i = 0; i < K; i++) s_tvalid[i] = ($urandom_range(99) < valid_pct);
    if (lane1_block > 0) begin
      s_tvalid[1] = 1'b0;
      lane1_block--;
      blocked = 1;
    end
    s_tdata = pack_col(idx);
    case (ready_mode)
      0: m_tready = 1'b1;
      1: m_tready = cyc[0];
      default: m_tready = ($urandom_range(1) == 1);
    endcase

    #1;
    if (blocked) check("ready_while_lane_low", s_tready, 3'b000);
    if (s_tready != '0) begin
      check("ready_all_equal", s_tready, 3'b111);
      check("ready_needs_all_valid", s_tvalid, 3'b111);
      idx++;
    end
    if (!model_busy) check("idle_quiet", {m_tvalid, s_tready}, 4'b0000);
    got = '{data: m_tdata, user: m_tuser, last: m_tlast};
    if (prev_stall) begin
      check("hold_valid", m_tvalid, 1'b1);
      check("hold_beat", got, prev_beat);
    end
    if (m_tvalid && m_tready) begin
      if (exp_q.size() == 0) check("extra_beat", 1'b1, 1'b0);
      else begin
        want = exp_q.pop_front();
        check("beat", got, want);
        if (acc_beats == 0) first_acc = cyc;
        last_acc = cyc;
        acc_beats++;
        if (exp_q.size() == 0 && model_busy) exp_done_next = 1;
      end
    end
    prev_stall = m_tvalid && !m_tready;
    prev_beat = got;
  endtask

  task automatic run_frame(input int w, input int h, input int mid_start_at, input int block_at);
    int n = 0;
    step(1'b1, w, h);
    while (model_busy && n < 3000) begin
      if (n == mid_start_at) step(1'b1, w + 3, h + 2);
      else begin
        if (n == block_at) lane1_block = 5;
        step(1'b0, 0, 0);
      end
      n++;
    end
    if (model_busy) begin
      check("frame_timeout", 1'b1, 1'b0);
      do_reset();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_m_tvalid", m_tvalid, 1'b0);
    check("rst_s_tready", s_tready, 3'b000);
    check("rst_busy", busy, 1'b0);
    exp_q.delete();
    model_busy = 0;
    exp_done_next = 0;
    exp_err_next = 0;
    prev_stall = 0;
    idx = 0;
    lane1_block = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    cfg_width = '0;
    cfg_height = '0;
    s_tvalid = '0;
    s_tdata = '0;
    m_tready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_outputs", {busy, done, err_cfg, m_tvalid, m_tuser, m_tlast, s_tready}, 9'd0);
    check("reset_tdata", m_tdata, 24'h0);
    @(negedge clk);
    rst = 1'b0;

    // Pin the model against hand-derived frame shape for w=4, h=2.
    build_model(4, 2);
    check("model_len_4x2", exp_q.size(), 12);
    check("model_sof", {exp_q[0].user, exp_q[1].user, exp_q[6].user}, 3'b100);
    check("model_eol", {exp_q[4].last, exp_q[5].last, exp_q[11].last}, 3'b011);
    check("model_pads", {exp_q[0].data, exp_q[5].data, exp_q[6].data, exp_q[11].data}, 96'h0);
    exp_q.delete();

    // Full-rate frame.
    valid_pct = 100; ready_mode = 0;
    run_frame(4, 2, -1, -1);
    check("t1_beats", acc_beats, 12);
    check("t1_back_to_back", last_acc - first_acc, 11);
    check("t1_done_latency", done_cyc - last_acc, 1);

    // Lane 1 starved for 5 cycles mid-row.
    run_frame(6, 1, -1, 3);
    check("t2_beats", acc_beats, 8);

    // Alternating sink ready.
    ready_mode = 1;
    run_frame(5, 2, -1, -1);
    check("t3_beats", acc_beats, 14);

    // Zero-dimension start, then the smallest frame.
    ready_mode = 0;
    step(1'b1, 0, 3);
    repeat (3) step(1'b0, 0, 0);
    build_model(1, 1);
    check("model_len_1x1", exp_q.size(), 3);
    check("model_1x1_flags", {exp_q[0].user, exp_q[0].last, exp_q[1].user, exp_q[1].last,
                              exp_q[2].user, exp_q[2].last}, 6'b100001);
    exp_q.delete();
    run_frame(1, 1, -1, -1);
    check("t4_beats", acc_beats, 3);

    // Reset on beat 5 of an 8x4 frame, then a clean frame.
    step(1'b1, 8, 4);
    for (int n = 0; n < 200 && acc_beats < 5; n++) step(1'b0, 0, 0);
    check("t5_reached_beat5", acc_beats, 5);
    do_reset();
    run_frame(3, 2, -1, -1);
    check("t5_clean_beats", acc_beats, 10);

    // Start while busy with different cfg is ignored.
    run_frame(3, 3, 4, -1);
    check("t6_beats", acc_beats, 15);

    // Randomized frames with random source gaps and sink stalls.
    for (int f = 0; f < 20; f++) begin
      valid_pct = $urandom_range(100, 50);
      ready_mode = $urandom_range(2);
      run_frame($urandom_range(6, 1), $urandom_range(4, 1),
                ($urandom_range(3) == 0) ? 5 : -1,
                ($urandom_range(3) == 0) ? 4 : -1);
    end
    repeat (3) step(1'b0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
